// File: rtl/lbp_code_engine_if.sv
// ---------------------------------------------------------------------------
// lbp_code_engine_if
//   Stream bundle between the gray-image fetch sequencer (master), the LBP
//   code engine (slave) and the result memory writer. The input side carries
//   framed pixel beats. The output side carries one code per packet.
//
// Signals
//   in_valid   beat valid               in_ready   engine can accept a beat
//   in_sop     beat is a centre         in_pix     centre / neighbour value
//   in_addr    result address (centre)  in_border  border flag (centre)
//   thr_i      compare offset (centre)
//   out_valid  code valid               out_ready  downstream accepts code
//   out_addr   result address           out_code   LBP code / label
//   frame_err  one-cycle abort pulse
// ---------------------------------------------------------------------------
interface lbp_code_engine_if #(
    parameter int PIX_W  = 8,
    parameter int NBR    = 8,
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sop;
    logic [PIX_W-1:0]  in_pix;
    logic [ADDR_W-1:0] in_addr;
    logic              in_border;
    logic [PIX_W-1:0]  thr_i;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [NBR-1:0]    out_code;
    logic              frame_err;

    modport master (
        output in_valid, in_sop, in_pix, in_addr, in_border, thr_i, out_ready,
        input  in_ready, out_valid, out_addr, out_code, frame_err
    );

    modport slave (
        input  in_valid, in_sop, in_pix, in_addr, in_border, thr_i, out_ready,
        output in_ready, out_valid, out_addr, out_code, frame_err
    );
endinterface

// File: rtl/lbp_code_engine.sv
// ---------------------------------------------------------------------------
// lbp_code_engine
//   Streaming local-binary-pattern engine. Each packet is one centre beat
//   (in_sop=1) followed by NBR neighbour beats. Neighbour k sets code bit k
//   when it is >= centre + thr_i. The threshold sum is kept at PIX_W+1 bits,
//   so it never wraps. The finished code and its address are held on the
//   output until downstream accepts them. An in_sop that arrives mid-packet
//   aborts the partial code, pulses frame_err and starts a new packet.
//
// Parameters
//   PIX_W   gray pixel width
//   NBR     neighbours per code, which is also the code width (4..16)
//   ADDR_W  result address width
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   bus     lbp_code_engine_if.slave (input beats, output codes, frame_err)
//
// Build option
//   LBP_UNIFORM_EN  when defined, out_code carries the uniform-pattern label:
//                   popcount if the circular code has <= 2 transitions,
//                   NBR+1 otherwise. When undefined, out_code is the raw code.
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a centre beat; non-centre beats are dropped
// COLLECT | thresholding neighbours into the code accumulator
// HOLD    | code/address presented, input stalled until handshake
//
module lbp_code_engine #(
    parameter int PIX_W  = 8,
    parameter int NBR    = 8,
    parameter int ADDR_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    lbp_code_engine_if.slave bus
);

    localparam int CNT_W = $clog2(NBR);
    localparam logic [CNT_W-1:0] LAST_NBR = CNT_W'(NBR - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [PIX_W:0]    ref_q;
    logic [ADDR_W-1:0] addr_q;
    logic              border_q;
    logic [NBR-1:0]    acc_q;
    logic [NBR-1:0]    acc_nx;
    logic [CNT_W-1:0]  cnt_q;

    logic [NBR-1:0]    code_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              frame_err_q;

    logic              accept;
    logic              hit;
    logic              load_centre;
    logic              load_nbr;
    logic              load_hold;
    logic              abort;
    logic [NBR-1:0]    code_final;

    assign bus.in_ready  = (state != HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign hit           = ({1'b0, bus.in_pix} >= ref_q);

    assign bus.out_valid = (state == HOLD);
    assign bus.out_code  = code_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        load_centre = 1'b0;
        load_nbr    = 1'b0;
        load_hold   = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.in_sop) begin
                    load_centre = 1'b1;
                    state_nx    = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (bus.in_sop) begin
                        // Early centre: restart the packet around it.
                        load_centre = 1'b1;
                        abort       = 1'b1;
                    end else begin
                        load_nbr = 1'b1;
                        if (cnt_q == LAST_NBR) begin
                            load_hold = 1'b1;
                            state_nx  = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The accumulator including the beat being accepted, so the HOLD
    // register can load the complete code in the same edge.
    always_comb begin
        acc_nx        = acc_q;
        acc_nx[cnt_q] = hit;
    end

`ifdef LBP_UNIFORM_EN
    function automatic logic [NBR-1:0] uniform_label(input logic [NBR-1:0] c);
        int trans;
        int ones;
        trans = 0;
        ones  = 0;
        for (int i = 0; i < NBR; i++) begin
            trans += int'(c[i] ^ c[(i + 1) % NBR]);
            ones  += int'(c[i]);
        end
        return (trans <= 2) ? NBR'(ones) : NBR'(NBR + 1);
    endfunction

    assign code_final = border_q ? '0 : uniform_label(acc_nx);
`else
    assign code_final = border_q ? '0 : acc_nx;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q       <= '0;
            addr_q      <= '0;
            border_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            out_addr_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= abort;
            if (load_centre) begin
                ref_q    <= {1'b0, bus.in_pix} + {1'b0, bus.thr_i};
                addr_q   <= bus.in_addr;
                border_q <= bus.in_border;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (load_nbr) begin
                acc_q <= acc_nx;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_hold) begin
                code_q     <= code_final;
                out_addr_q <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_lbp_code_engine.sv
// ---------------------------------------------------------------------------
// tb_lbp_code_engine
//   Self-checking bench for lbp_code_engine: an 8-neighbour 8-bit instance
//   plus a 4-neighbour 10-bit instance. Expected codes come from a
//   behavioural model of the thresholding and labelling rules.
// ---------------------------------------------------------------------------
module tb_lbp_code_engine;

    localparam int NBR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lbp_code_engine_if #(.PIX_W(8),  .NBR(8), .ADDR_W(14)) bus ();
    lbp_code_engine_if #(.PIX_W(10), .NBR(4), .ADDR_W(14)) bus4 ();

    lbp_code_engine #(.PIX_W(8), .NBR(8), .ADDR_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lbp_code_engine #(.PIX_W(10), .NBR(4), .ADDR_W(14)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int err_cycles = 0;

    typedef struct {
        logic [31:0] code;
        logic [31:0] addr;
        int          cyc;
    } obs_t;

    obs_t obs_q[$];
    int   last_obs_cyc;

    always @(posedge clk) cyc++;

    // Handshakes are observed on the falling edge, ahead of the rising edge
    // that completes them.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            obs_q.push_back('{32'(bus.out_code), 32'(bus.out_addr), cyc});
        if (bus.frame_err === 1'b1)
            err_cycles++;
    end

    // Reference: bit k set when neighbour k >= centre + thr (no wrap).
    function automatic int model_code(input int n, input int centre, input int thr,
                                      input int nb[16], input bit border);
        int code;
        int trans;
        int ones;
        code  = 0;
        trans = 0;
        ones  = 0;
        if (border) return 0;
        for (int k = 0; k < n; k++)
            if (nb[k] >= centre + thr) code |= (1 << k);
`ifdef LBP_UNIFORM_EN
        for (int k = 0; k < n; k++) begin
            if (((code >> k) & 1) != ((code >> ((k + 1) % n)) & 1)) trans++;
            ones += (code >> k) & 1;
        end
        return (trans <= 2) ? ones : n + 1;
`else
        return code;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input bit sop, input int pix, input int addr,
                             input bit border, input int thr);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.in_sop    = sop;
        bus.in_pix    = 8'(pix);
        bus.in_addr   = 14'(addr);
        bus.in_border = border;
        bus.thr_i     = 8'(thr);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Neighbour beats carry junk in the centre-only fields.
    task automatic send_nbr(input int pix);
        send_beat(1'b0, pix, int'($urandom), 1'($urandom), int'($urandom));
    endtask

    task automatic send_packet(input int centre, input int thr, input int addr,
                               input bit border, input int nb[16]);
        send_beat(1'b1, centre, addr, border, thr);
        for (int k = 0; k < NBR; k++) send_nbr(nb[k]);
    endtask

    task automatic expect_out(input string name, input int exp_code, input int exp_addr);
        int n;
        obs_t o;
        n = 0;
        while (obs_q.size() == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s no_output_handshake required code=%0h addr=%0h", name, exp_code, exp_addr);
        end else begin
            o = obs_q.pop_front();
            last_obs_cyc = o.cyc;
            if (o.code !== 32'(exp_code) || o.addr !== 32'(exp_addr)) begin
                miscompares++;
                $display("FAIL %s code=%0h addr=%0h required code=%0h addr=%0h",
                         name, o.code, o.addr, exp_code, exp_addr);
            end
        end
    endtask

    task automatic check_latency(input string name);
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid=%b required=1 after last neighbour", name, bus.out_valid);
        end
    endtask

    task automatic check_no_output(input string name);
        vectors++;
        if (obs_q.size() != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s queued=%0d out_valid=%b required queued=0 out_valid=0",
                     name, obs_q.size(), bus.out_valid);
            obs_q.delete();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_code !== 8'h00 || bus.out_addr !== 14'h0 ||
            bus.frame_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state valid=%b code=%h addr=%h err=%b ready=%b required 0,00,0000,0,1",
                     bus.out_valid, bus.out_code, bus.out_addr, bus.frame_err, bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_vector();
        int nb[16] = '{10, 60, 50, 49, 80, 0, 255, 50, 0, 0, 0, 0, 0, 0, 0, 0};
        send_packet(50, 0, 14'h1234, 1'b0, nb);
        check_latency("basic_latency");
        expect_out("basic_vector", model_code(NBR, 50, 0, nb, 1'b0), 14'h1234);
    endtask

    task automatic test_threshold();
        int nb[16];
        for (int k = 0; k < 16; k++) nb[k] = 210;
        send_packet(200, 10, 14'h0011, 1'b0, nb);
        expect_out("thr_equal_all_set", model_code(NBR, 200, 10, nb, 1'b0), 14'h0011);
        for (int k = 0; k < 16; k++) nb[k] = 209;
        send_packet(200, 10, 14'h0022, 1'b0, nb);
        expect_out("thr_below_all_clear", model_code(NBR, 200, 10, nb, 1'b0), 14'h0022);
        for (int k = 0; k < 16; k++) nb[k] = 255;
        send_packet(1, 255, 14'h0033, 1'b0, nb);
        expect_out("thr_max_no_wrap", model_code(NBR, 1, 255, nb, 1'b0), 14'h0033);
    endtask

    task automatic test_border();
        int nb[16];
        for (int k = 0; k < 16; k++) nb[k] = 255;
        send_packet(3, 0, 14'h2ABC, 1'b1, nb);
        check_latency("border_latency");
        expect_out("border_zero", 0, 14'h2ABC);
    endtask

    task automatic test_backpressure();
        int nb[16];
        int exp;
        logic [7:0] held_code;
        logic [13:0] held_addr;
        for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
        exp = model_code(NBR, 128, 0, nb, 1'b0);
        bus.out_ready = 1'b0;
        send_packet(128, 0, 14'h3001, 1'b0, nb);
        check_latency("hold_latency");
        held_code = bus.out_code;
        held_addr = bus.out_addr;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_code !== held_code || bus.out_addr !== held_addr) begin
                miscompares++;
                $display("FAIL hold_stable ready=%b valid=%b code=%h addr=%h required 0,1,%h,%h",
                         bus.in_ready, bus.out_valid, bus.out_code, bus.out_addr, held_code, held_addr);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release valid=%b ready=%b required 0,1", bus.out_valid, bus.in_ready);
        end
        expect_out("hold_code", exp, 14'h3001);
        check_no_output("hold_single_handshake");
    endtask

    task automatic test_frame_recovery();
        int nb[16];
        int err0;
        for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
        err0 = err_cycles;
        send_beat(1'b1, 100, 14'h0001, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_nbr(int'($urandom_range(0, 255)));
        send_beat(1'b1, 30, 14'h0777, 1'b0, 5);
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err_pulse frame_err=%b required=1", bus.frame_err);
        end
        for (int k = 0; k < NBR; k++) begin
            send_nbr(nb[k]);
            if (k == 0) begin
                vectors++;
                if (bus.frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL frame_err_width frame_err=%b required=0", bus.frame_err);
                end
            end
        end
        expect_out("frame_recovered", model_code(NBR, 30, 5, nb, 1'b0), 14'h0777);
        check_no_output("frame_partial_dropped");
        for (int k = 0; k < 3; k++) send_beat(1'b0, 7, 14'h1111, 1'b0, 0);
        for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
        send_packet(90, 3, 14'h0555, 1'b0, nb);
        expect_out("idle_drop_clean", model_code(NBR, 90, 3, nb, 1'b0), 14'h0555);
        check_no_output("idle_drop_no_extra");
        vectors++;
        if (err_cycles - err0 != 1) begin
            miscompares++;
            $display("FAIL frame_err_count cycles=%0d required=1", err_cycles - err0);
        end
    endtask

    task automatic test_reset_mid();
        int nb[16];
        send_beat(1'b1, 20, 14'h0099, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_nbr(255);
        pulse_reset();
        repeat (12) @(posedge clk);
        #1;
        check_no_output("rst_collect_no_output");
        for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
        send_packet(77, 0, 14'h0abc, 1'b0, nb);
        expect_out("rst_collect_recover", model_code(NBR, 77, 0, nb, 1'b0), 14'h0abc);
        bus.out_ready = 1'b0;
        send_packet(10, 0, 14'h0def, 1'b0, nb);
        check_latency("rst_hold_latency");
        pulse_reset();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_code !== 8'h00 || bus.out_addr !== 14'h0) begin
            miscompares++;
            $display("FAIL rst_hold_drop valid=%b code=%h addr=%h required 0,00,0000",
                     bus.out_valid, bus.out_code, bus.out_addr);
        end
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_no_output("rst_hold_no_output");
    endtask

    task automatic test_back_to_back();
        int nb[16];
        int exp_code[3];
        int exp_addr[3];
        int prev;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
            exp_code[p] = model_code(NBR, 60 + p * 40, p, nb, 1'b0);
            exp_addr[p] = 100 + p;
            send_packet(60 + p * 40, p, 100 + p, 1'b0, nb);
        end
        prev = 0;
        for (int p = 0; p < 3; p++) begin
            expect_out("b2b_code", exp_code[p], exp_addr[p]);
            if (p > 0) begin
                vectors++;
                if (last_obs_cyc - prev != NBR + 2) begin
                    miscompares++;
                    $display("FAIL b2b_throughput cycles=%0d required=%0d", last_obs_cyc - prev, NBR + 2);
                end
            end
            prev = last_obs_cyc;
        end
    endtask

    task automatic test_random();
        int nb[16];
        int centre;
        int thr;
        int addr;
        bit border;
        for (int p = 0; p < 40; p++) begin
            centre = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       thr = 0;
                1:       thr = 255;
                default: thr = int'($urandom_range(0, 40));
            endcase
            addr   = int'($urandom_range(0, 16383));
            border = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 16; k++) nb[k] = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_packet(centre, thr, addr, border, nb);
            expect_out("random_packet", model_code(NBR, centre, thr, nb, border), addr);
        end
    endtask

    task automatic send_beat4(input bit sop, input int pix);
        int n;
        n = 0;
        bus4.in_valid  = 1'b1;
        bus4.in_sop    = sop;
        bus4.in_pix    = 10'(pix);
        bus4.in_addr   = 14'h0042;
        bus4.in_border = 1'b0;
        bus4.thr_i     = 10'd0;
        while (bus4.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus4.in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL nbr4_accept_timeout in_ready=%b required=1", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic test_nbr4();
        int nb[16] = '{600, 500, 512, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int exp;
        exp = model_code(4, 512, 0, nb, 1'b0);
        send_beat4(1'b1, 512);
        for (int k = 0; k < 4; k++) send_beat4(1'b0, nb[k]);
        vectors++;
        if (bus4.out_valid !== 1'b1 || bus4.out_code !== 4'(exp) || bus4.out_addr !== 14'h0042) begin
            miscompares++;
            $display("FAIL nbr4_code valid=%b code=%h addr=%h required 1,%h,0042",
                     bus4.out_valid, bus4.out_code, bus4.out_addr, 4'(exp));
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus4.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nbr4_release valid=%b required=0", bus4.out_valid);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sop     = 1'b0;
        bus.in_pix     = '0;
        bus.in_addr    = '0;
        bus.in_border  = 1'b0;
        bus.thr_i      = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_sop    = 1'b0;
        bus4.in_pix    = '0;
        bus4.in_addr   = '0;
        bus4.in_border = 1'b0;
        bus4.thr_i     = '0;
        bus4.out_ready = 1'b0;

        test_reset();
        test_basic_vector();
        test_threshold();
        test_border();
        test_backpressure();
        test_frame_recovery();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_nbr4();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
